// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters that drive the decode stall.
// Define RF_BYPASS_EN to forward a final writeback straight to the read ports.
module regfile_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int MAXPEND = 3,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(MAXPEND + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    input  logic [NRD-1:0]       rd_use,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_ready,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic                 stall,
    output logic [NREG-1:0]      busy_mask,
    output logic                 wb_err
);

    logic [XLEN-1:0] regs     [NREG];
    logic [CW-1:0]   pend     [NREG];
    logic [CW-1:0]   pend_nxt [NREG];
    logic            accepted;

    assign iss_ready = (pend[iss_rd] != CW'(MAXPEND)) || (iss_rd == '0);
    assign accepted  = iss_valid && iss_ready;

    // Flush keeps only the same-cycle claim; otherwise inc and dec cancel.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            pend_nxt[r] = '0;
            if (r != 0) begin
                if (flush)
                    pend_nxt[r] = (accepted && iss_rd == AW'(r)) ? CW'(1) : '0;
                else
                    pend_nxt[r] = pend[r]
                                + CW'(accepted && iss_rd == AW'(r))
                                - CW'(wb_valid && wb_rd == AW'(r) && pend[r] != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
            wb_err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++)
                pend[r] <= pend_nxt[r];
            if (wb_valid && wb_rd != '0) begin
                regs[wb_rd] <= wb_data;
                if (pend[wb_rd] == '0)
                    wb_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          byp;
        assign a = rd_addr[i*AW +: AW];
`ifdef RF_BYPASS_EN
        // Only the last owed result may be forwarded; older ones stay busy.
        assign byp = wb_valid && (wb_rd == a) && (a != '0) && (pend[a] == CW'(1));
`else
        assign byp = 1'b0;
`endif
        assign rd_data[i*XLEN +: XLEN] = byp ? wb_data : regs[a];
        assign rd_busy[i] = (pend[a] != '0) && (a != '0) && !byp;
    end

    for (genvar r = 0; r < NREG; r++) begin : g_mask
        assign busy_mask[r] = (pend[r] != '0);
    end

    assign stall = (|(rd_use & rd_busy)) || (iss_valid && !iss_ready);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard against an array/integer reference model.
module tb_regfile_scoreboard;

    localparam int XLEN    = 32;
    localparam int NREG    = 32;
    localparam int NRD     = 2;
    localparam int MAXPEND = 3;
    localparam int AW      = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_use;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                wb_valid;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic                stall;
    logic [NREG-1:0]     busy_mask;
    logic                wb_err;

    int checks = 0;
    int errors = 0;

    int              pend_m [NREG];
    logic [XLEN-1:0] regs_m [NREG];
    logic            err_m;

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .MAXPEND(MAXPEND)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
        .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .stall(stall), .busy_mask(busy_mask), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            pend_m[r] = 0;
            regs_m[r] = '0;
        end
        err_m = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        acc = iss_valid && (iss_rd == 0 || pend_m[iss_rd] != MAXPEND);
        if (wb_valid && wb_rd != 0) begin
            if (pend_m[wb_rd] == 0) err_m = 1'b1;
            regs_m[wb_rd] = wb_data;
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) pend_m[r] = 0;
            if (acc && iss_rd != 0) pend_m[iss_rd] = 1;
        end else begin
            if (wb_valid && wb_rd != 0 && pend_m[wb_rd] > 0) pend_m[wb_rd]--;
            if (acc && iss_rd != 0) pend_m[iss_rd]++;
        end
    endtask

    task automatic check_all();
        logic [NREG-1:0]     bm;
        logic [NRD-1:0]      eb;
        logic [NRD*XLEN-1:0] ed;
        logic [AW-1:0]       a;
        logic                er, es, byp;
        er = (iss_rd == 0) || (pend_m[iss_rd] != MAXPEND);
        for (int r = 0; r < NREG; r++) bm[r] = (pend_m[r] != 0);
        for (int i = 0; i < NRD; i++) begin
            a = rd_addr[i*AW +: AW];
            byp = 1'b0;
`ifdef RF_BYPASS_EN
            byp = wb_valid && (wb_rd == a) && (a != 0) && (pend_m[a] == 1);
`endif
            ed[i*XLEN +: XLEN] = byp ? wb_data : regs_m[a];
            eb[i] = (a != 0) && (pend_m[a] != 0) && !byp;
        end
        es = (|(rd_use & eb)) || (iss_valid && !er);
        chk("iss_ready", 64'(iss_ready), 64'(er));
        chk("stall",     64'(stall),     64'(es));
        chk("busy_mask", 64'(busy_mask), 64'(bm));
        chk("rd_busy",   64'(rd_busy),   64'(eb));
        chk("rd_data",   64'(rd_data),   64'(ed));
        chk("wb_err",    64'(wb_err),    64'(err_m));
    endtask

    task automatic settle_check();
        #3;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic cyc();
        settle_check();
        tick();
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
        flush     = 1'b0;
        rd_use    = '0;
        iss_rd    = '0;
        wb_rd     = '0;
        wb_data   = '0;
    endtask

    task automatic claim(input int r);
        idle();
        iss_valid = 1'b1;
        iss_rd = AW'(r);
    endtask

    task automatic wb(input int r, input logic [XLEN-1:0] d);
        idle();
        wb_valid = 1'b1;
        wb_rd = AW'(r);
        wb_data = d;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle();
        model_reset();
        settle_check();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Populate state, then pulse reset mid-cycle.
        claim(6); cyc();
        wb(6, 32'h1234); cyc();
        wb(6, 32'h5678); cyc();
        idle(); rd_addr = {AW'(5), AW'(6)}; claim(5); cyc();
        idle(); settle_check();
        chk("pre_rst_err", 64'(wb_err), 64'd1);
        #1 rst = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_async_data", 64'(rd_data), 64'd0);
        chk("rst_async_mask", 64'(busy_mask), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        // Claim x5, write it back two cycles later.
        claim(5); cyc();
        idle(); rd_addr = {AW'(0), AW'(5)}; rd_use = 2'b01; cyc();
        settle_check();
        chk("x5_stall", 64'(stall), 64'd1);
        tick();
        wb(5, 32'hDEADBEEF); rd_use = 2'b01; settle_check();
`ifdef RF_BYPASS_EN
        chk("x5_byp_stall", 64'(stall), 64'd0);
        chk("x5_byp_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
`else
        chk("x5_nobyp_stall", 64'(stall), 64'd1);
`endif
        tick();
        idle(); rd_use = 2'b01; settle_check();
        chk("x5_after_stall", 64'(stall), 64'd0);
        chk("x5_after_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
        tick();

        // Saturate x7.
        claim(7); cyc(); cyc(); cyc();
        claim(7); wb_valid = 1'b1; wb_rd = AW'(7); wb_data = 32'h77; settle_check();
        chk("x7_ready_full", 64'(iss_ready), 64'd0);
        chk("x7_stall_full", 64'(stall), 64'd1);
        tick();
        claim(7); settle_check();
        chk("x7_ready_after", 64'(iss_ready), 64'd1);
        idle(); tick();
        wb(7, 32'h70); cyc();
        wb(7, 32'h71); cyc();

        // Register 0 is hardwired.
        claim(0); wb_valid = 1'b1; wb_rd = '0; wb_data = 32'hFFFFFFFF;
        rd_addr = {AW'(0), AW'(0)}; rd_use = 2'b11; settle_check();
        chk("x0_busy", 64'(rd_busy), 64'd0);
        tick();
        idle(); settle_check();
        chk("x0_data", 64'(rd_data), 64'd0);
        chk("x0_mask0", 64'(busy_mask[0]), 64'd0);
        chk("x0_err", 64'(wb_err), 64'd0);
        tick();

        // Simultaneous claim and writeback on x2.
        claim(2); rd_addr = {AW'(0), AW'(2)}; cyc();
        claim(2); wb_valid = 1'b1; wb_rd = AW'(2); wb_data = 32'h22; cyc();
        idle(); settle_check();
        chk("x2_mask", 64'(busy_mask[2]), 64'd1);
        chk("x2_data", 64'(rd_data[31:0]), 64'h22);
        tick();
        wb(2, 32'h23); cyc();

        // Flush with a concurrent claim.
        claim(3); cyc();
        claim(4); cyc();
        claim(9); flush = 1'b1; cyc();
        idle(); settle_check();
        chk("flush_mask", 64'(busy_mask), 64'(32'h200));
        tick();
        wb(3, 32'h11); rd_addr = {AW'(9), AW'(3)}; cyc();
        idle(); settle_check();
        chk("flush_wb_data", 64'(rd_data[31:0]), 64'h11);
        chk("flush_wb_err", 64'(wb_err), 64'd1);
        tick();

        // Randomized traffic over a small register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = AW'($urandom_range(0, 7));
            wb_valid  = 1'($urandom_range(0, 1));
            wb_rd     = AW'($urandom_range(0, 7));
            wb_data   = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            rd_addr   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            rd_use    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) rd_addr[AW-1:0] = wb_rd;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with an integrated write scoreboard for the pipelined RISC-V core. It holds the architectural registers and tracks, per register, how many issued instructions still owe a writeback. From this it generates the decode-stage stall, so the decode stage no longer needs ad-hoc rd-equality comparisons. An optional writeback-to-read bypass removes the stall on the cycle the last owed result arrives.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of registers (power of two, ≥2); AW = clog2(NREG)
- NRD, 2, number of read ports
- MAXPEND, 3, maximum in-flight writes per register; counter width CW = clog2(MAXPEND+1)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  one clock; reset is asynchronous and active-high
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_use  in  NRD  port i is actually a source of the decoding instruction
- rd_data  out  NRD*XLEN  combinational read data
- rd_busy  out  NRD  port i source has an unresolved pending write
- iss_valid  in  1  decode issues an instruction that writes iss_rd
- iss_rd  in  AW  destination being claimed
- iss_ready  out  1  claim can be accepted this cycle
- wb_valid  in  1  writeback strobe
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback value
- flush  in  1  discard all pending claims (branch redirect)
- stall  out  1  decode must hold
- busy_mask  out  NREG  bit r = pend[r] != 0
- wb_err  out  1  sticky: writeback arrived for a register with pend = 0

## Operation
- State: array regs[NREG] of XLEN bits; counters pend[NREG] of CW bits; flop wb_err.
- Register 0 is hardwired zero: it reads 0, is never busy, ignores claims and writes, and iss_ready is always 1 for iss_rd = 0.
- Claim: accepted = iss_valid & iss_ready. iss_ready = (pend[iss_rd] != MAXPEND) | (iss_rd == 0).
- Counter update per register r, at the rising edge:
  - inc = accepted & iss_rd == r; dec = wb_valid & wb_rd == r & pend[r] != 0.
  - With flush: pend[r] ← inc ? 1 : 0. Flush clears older claims; the same-cycle claim survives.
  - Without flush: pend[r] ← pend[r] + inc − dec, so inc & dec leaves it unchanged.
- Writeback: regs[wb_rd] ← wb_data whenever wb_valid and wb_rd != 0, regardless of pend or flush.
- wb_err is set when wb_valid, wb_rd != 0 and pend[wb_rd] == 0. It is cleared only by rst.
- Read port i: rd_data = regs[rd_addr_i]. rd_busy_i = (pend[rd_addr_i] != 0) & (rd_addr_i != 0), modified by the bypass (Configuration).
- stall = |(rd_use & rd_busy) | (iss_valid & ~iss_ready).
- Counter arithmetic saturates by construction: an increment past MAXPEND cannot be accepted, and a decrement below 0 is ignored.

## Timing
- Reset values: regs all 0, pend all 0, wb_err 0. Resulting outputs: rd_data 0, rd_busy 0, stall 0, iss_ready 1, busy_mask 0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. The outputs above then hold until the first edge after release.
- Reads are zero-latency combinational.
- A write becomes visible in rd_data the cycle after wb_valid (unless bypassed).
- A claim accepted at edge N makes busy_mask and rd_busy assert from cycle N+1.
- iss_ready, rd_busy and stall depend combinationally on same-cycle inputs. They have no dependence on iss_valid except through stall.

## Configuration
- RF_BYPASS_EN defined:
  - If wb_valid, wb_rd == rd_addr_i != 0 and pend[rd_addr_i] == 1, then rd_data_i = wb_data and rd_busy_i = 0 in that same cycle.
  - With pend > 1 the port stays busy and shows the array value.
- RF_BYPASS_EN undefined:
  - No bypass path. rd_busy_i clears and the new data appears one cycle after the final writeback.
  - A dependent instruction therefore sees one extra stall cycle.

## Test plan
- Reset with rst pulsed mid-cycle after writes → all rd_data 0, busy_mask 0, wb_err 0, iss_ready 1 asynchronously.
- Claim x5, then wb x5 = 0xDEADBEEF two cycles later with rd_addr0 = 5, rd_use0 = 1:
  - stall = 1 while pending.
  - With RF_BYPASS_EN: stall = 0 and rd_data0 = 0xDEADBEEF in the wb cycle.
  - Without RF_BYPASS_EN: stall = 0 and the data appear one cycle later.
- Claim x7 three times (MAXPEND = 3) → iss_ready = 0 and stall = 1 on the fourth claim. A same-cycle wb x7 does not unblock iss_ready; it rises the following cycle.
- Claim x3 and x4, then flush concurrent with a claim of x9 → busy_mask equals only bit 9. A later wb x3 = 0x11 writes 0x11 and sets wb_err.
- Claim/wb/read x0 with 0xFFFFFFFF → rd_data 0, rd_busy 0, busy_mask[0] 0, wb_err 0.
- Simultaneous claim and wb of x2 with pend = 1 → pend stays 1 and busy_mask[2] stays 1. The register holds the new data next cycle.
